// File: rtl/until_monitor_pkg.sv
// Shared types and fail-cause codes for the until_monitor run-time property checker.
package until_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] FAIL_B  = 2'b01;
  localparam logic [1:0] FAIL_C  = 2'b10;
  localparam logic [1:0] FAIL_BC = 2'b11;

endpackage

// File: rtl/until_monitor_if.sv
// Trace inputs and result outputs of until_monitor; master = trace driver, slave = monitor.
interface until_monitor_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             a;
  logic             b;
  logic             c;
  logic             d;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_cause;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic [CNT_W-1:0] ignored_count;

  modport master (
    output a, b, c, d,
    input  busy, pass, fail, fail_cause, pass_count, fail_count, ignored_count
  );

  modport slave (
    input  a, b, c, d,
    output busy, pass, fail, fail_cause, pass_count, fail_count, ignored_count
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/until_monitor.sv
// Checks "$rose(a) |=> (b ##2 c) until[_with] d[*2]" (weak) and reports per-attempt
// pass/fail pulses plus saturating pass/fail/ignored-trigger counters.
module until_monitor
  import until_monitor_pkg::*;
#(
  parameter bit          UNTIL_WITH = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic           clock,
  input  logic           reset,
  until_monitor_if.slave mon
);

  state_t     state;
  state_t     state_next;
  logic       a_prev;
  logic       d_prev;
  logic       d_prev_valid;
  logic [1:0] c_pipe;  // [0]: check pushed last cycle, [1]: check due this cycle
  logic       rise;
  logic       released;
  logic       push;
  logic       b_viol;
  logic       c_viol;
  logic       viol;
  logic       pass_c;
  logic [1:0] cause_c;
  logic       pass_q;
  logic       fail_q;
  logic [1:0] cause_q;

  assign rise = mon.a & ~a_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (rise) state_next = RUN;
      RUN: begin
        if (viol) begin
          state_next = IDLE;
        end else if (released) begin
          state_next = (push | c_pipe[0]) ? DRAIN : IDLE;
        end
      end
      DRAIN: if (viol || !c_pipe[0]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Obligation, violation and verdict for the current cycle.
  always_comb begin
    released = 1'b0;
    push     = 1'b0;
    b_viol   = 1'b0;
    c_viol   = 1'b0;
    cause_c  = 2'b00;
    if (state == RUN) begin
      released = d_prev_valid & d_prev & mon.d;
      push     = ~released | UNTIL_WITH;
      b_viol   = push & ~mon.b;
    end
    if (state != IDLE) begin
      c_viol = c_pipe[1] & ~mon.c;
    end
    viol = b_viol | c_viol;
    if (b_viol && c_viol) begin
      cause_c = FAIL_BC;
    end else if (b_viol) begin
      cause_c = FAIL_B;
    end else if (c_viol) begin
      cause_c = FAIL_C;
    end
    pass_c = ~viol & (((state == RUN) & released & ~push & ~c_pipe[0]) |
                      ((state == DRAIN) & ~c_pipe[0]));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_prev       <= 1'b0;
      d_prev       <= 1'b0;
      d_prev_valid <= 1'b0;
      c_pipe       <= 2'b00;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      cause_q      <= 2'b00;
    end else begin
      a_prev       <= mon.a;
      d_prev       <= mon.d;
      d_prev_valid <= (state == RUN) && (state_next == RUN);
      c_pipe       <= viol ? 2'b00 : {c_pipe[0], push};
      pass_q       <= pass_c;
      fail_q       <= viol;
      cause_q      <= cause_c;
    end
  end

  assign mon.busy       = (state != IDLE);
  assign mon.pass       = pass_q;
  assign mon.fail       = fail_q;
  assign mon.fail_cause = cause_q;

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (pass_c),
    .count (mon.pass_count)
  );

  sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (viol),
    .count (mon.fail_count)
  );

  sat_counter #(.W(CNT_W)) u_ign_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (rise & (state != IDLE)),
    .count (mon.ignored_count)
  );

endmodule

// File: doc/until_monitor.md
Name: until_monitor

Overview:
- Synthesizable run-time checker. It consumes the four trace signals A, B, C, D that the formal sequencers drive.
- It evaluates in RTL the property "$rose(A) |=> (B ##2 C) until[_with] D[*2]", weak form.
- It reports per-attempt pass/fail pulses and saturating counters.
- It sits beside the sequencer in sim/formal benches, so the same traces can be cross-checked against the SVA result.

Parameters:
- UNTIL_WITH, 0, 0 gives until (obligation strictly before release); 1 gives until_with (obligation also on the release cycle).
- CNT_W, 8, width of pass_count, fail_count and ignored_count.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- a  input  1  trigger signal.
- b  input  1  LHS first term.
- c  input  1  LHS second term, checked 2 cycles after b.
- d  input  1  release signal; the release condition is two consecutive highs.
- busy  output  1  attempt in RUN or DRAIN.
- pass  output  1  one-cycle pulse: attempt released and all C checks met.
- fail  output  1  one-cycle pulse: attempt violated.
- fail_cause  output  2  valid with fail: 01 = B low, 10 = C low, 11 = both in the same cycle.
- pass_count  output  CNT_W  saturating count of pass pulses.
- fail_count  output  CNT_W  saturating count of fail pulses.
- ignored_count  output  CNT_W  saturating count of triggers dropped because not IDLE.

Behaviour:
- Reset (synchronous) clears everything:
  - all outputs, counters and the C pipe go to 0;
  - a_prev goes to 0, so A high in the first cycle after reset counts as a rise;
  - state goes to IDLE.
  - Reset mid-attempt aborts the attempt silently, with no pass/fail pulse.
- Trigger: rise = a & !a_prev at cycle t.
  - In IDLE, the next state is RUN, and cycle t+1 is the first obligation cycle.
  - In RUN or DRAIN, the trigger is dropped and ignored_count increments.
- States: IDLE, RUN, DRAIN; the encoding is in the package.
- RUN at cycle k:
  - d_prev holds D[k-1], and is valid only if k-1 >= t+1 (it is invalid on the first RUN cycle).
  - release = d_prev_valid & d_prev & d.
  - obligation = !release | UNTIL_WITH.
  - If obligation: b must be 1, else fail; push a C check into the 2-stage pipe. The check is evaluated at k+2 and requires c = 1.
  - On release: go to DRAIN, or straight to IDLE with pass if the pipe holds no further checks after this cycle.
  - With no release, RUN continues indefinitely. This is weak semantics: no failure for an unreleased attempt.
- DRAIN: no new pushes. Pending C checks continue. When the pipe empties without violation, go to IDLE and pulse pass.
- Any violation, in RUN or DRAIN, does all of the following:
  - goes to IDLE;
  - clears the pipe and d_prev_valid;
  - pulses fail with its cause.
  - B and C violations detected in the same cycle give fail_cause = 11.
- Pass and fail are registered, asserted the cycle after the deciding cycle, and mutually exclusive.
- A trigger on the deciding cycle is ignored, because the state is not yet IDLE.
- busy = (state != IDLE).
- Counters saturate at all-ones and never wrap. A pulse and its counter increment land in the same cycle.

Decomposition:
- Package until_monitor_pkg holds:
  - state_t enum (IDLE, RUN, DRAIN);
  - FAIL_B = 2'b01, FAIL_C = 2'b10, FAIL_BC = 2'b11.
- Sub-module sat_counter, parameter W, with ports clock, reset, inc, count. It is instanced three times.

Test Plan:
- Until mode. Traces: A _-__, B high 2-5, C high 4-7, D high 5-6 (UNTIL_WITH=0).
  - Required: release at 6, last C check at 7, pass=1 at cycle 8, fail never, pass_count=1.
- Until mode. D high at 4 and 6 only (no consecutive pair), other traces as above.
  - Required: B low at 6 while in RUN, fail=1 at 7, fail_cause=01, busy=0 at 7.
- Until_with mode. Same traces as the first scenario (UNTIL_WITH=1).
  - Required: obligation on release cycle 6 with B=0, fail=1 at 7, fail_cause=01.
- Until_with mode. B high 2-6, C high 4-8, D high 5-6 (UNTIL_WITH=1).
  - Required: C@8 checked in DRAIN, pass=1 at 9, fail_count=0.
- A rises at 1 and again at 4 during RUN.
  - Required: ignored_count=1, exactly one pass or fail for the first attempt.
  - Also: reset asserted at cycle 5 gives all outputs 0 at 6 with no pulse.
- Force 300 passing attempts with CNT_W=8.
  - Required: pass_count holds 255 and does not wrap.
